// File: rtl/rect_pkg.sv
// rect_pkg: shared constants and types for the rectangle stream receiver
package rect_pkg;
  localparam int DATA_WIDTH     = 16;
  localparam int WORDS_PER_RECT = 6;
  localparam int F_FLAGS        = 0;
  localparam int F_X            = 1;
  localparam int F_Y            = 2;
  localparam int F_W            = 3;
  localparam int F_H            = 4;
  localparam int F_COLOR        = 5;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] flags;
    logic [DATA_WIDTH-1:0] x;
    logic [DATA_WIDTH-1:0] y;
    logic [DATA_WIDTH-1:0] w;
    logic [DATA_WIDTH-1:0] h;
    logic [DATA_WIDTH-1:0] color;
  } rect_t;
  typedef enum logic [1:0] {IDLE, RECV, DONE} rx_state_t;
endpackage

// File: rtl/rect_bank.sv
// rect_bank: double-banked rectangle store, one word write port, one registered record read port
module rect_bank
  import rect_pkg::*;
#(
  parameter int RECT_COUNT = 64,
  parameter int IW         = $clog2(RECT_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  wr_bank,
  input  logic [IW-1:0]         wr_idx,
  input  logic [2:0]            wr_field,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_bank,
  input  logic [IW-1:0]         rd_idx,
  output rect_t                 rd_data
);
  logic [DATA_WIDTH-1:0] mem [WORDS_PER_RECT][2*RECT_COUNT];
  logic [DATA_WIDTH-1:0] fld_d [WORDS_PER_RECT];
  logic [DATA_WIDTH-1:0] fld_q [WORDS_PER_RECT];
  // word write into one field array; bank bit is the address MSB
  always_ff @(posedge clk) begin
    if (we) mem[wr_field][{wr_bank, wr_idx}] <= wr_data;
  end
  // all six field arrays are read in parallel to form one record
  always_comb begin
    for (int f = 0; f < WORDS_PER_RECT; f++) fld_d[f] = mem[f][{rd_bank, rd_idx}];
  end
  // read data register, cleared on reset so the rasterizer sees zeros
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int f = 0; f < WORDS_PER_RECT; f++) fld_q[f] <= '0;
    end else begin
      for (int f = 0; f < WORDS_PER_RECT; f++) fld_q[f] <= fld_d[f];
    end
  end
  assign rd_data = {fld_q[F_FLAGS], fld_q[F_X], fld_q[F_Y], fld_q[F_W], fld_q[F_H], fld_q[F_COLOR]};
endmodule

// File: rtl/rect_stream_receiver.sv
// rect_stream_receiver: assembles the copy stream into records in the back bank and swaps banks on vsync
module rect_stream_receiver
  import rect_pkg::*;
#(
  parameter int RECT_COUNT = 64,
  parameter int IW         = $clog2(RECT_COUNT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  copy_start,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  swap,
  input  logic [IW-1:0]         rd_idx,
  output logic [DATA_WIDTH-1:0] rd_flags,
  output logic [DATA_WIDTH-1:0] rd_x,
  output logic [DATA_WIDTH-1:0] rd_y,
  output logic [DATA_WIDTH-1:0] rd_w,
  output logic [DATA_WIDTH-1:0] rd_h,
  output logic [DATA_WIDTH-1:0] rd_color,
  output logic                  frame_ready,
  output logic                  front_sel,
  output logic                  overrun,
  output logic                  busy
);
  rx_state_t   state_q, state_d;
  logic [2:0]  word_cnt_q, word_cnt_d;
  logic [IW-1:0] rect_idx_q, rect_idx_d;
  logic        front_sel_q, front_sel_d;
  logic        frame_ready_q, frame_ready_d;
  logic        overrun_q, overrun_d;
  logic        rx, we, wr_bank, last_word, last_rect;
  logic [2:0]  wr_field;
  logic [IW-1:0] wr_idx;
  rect_t       rd_rect;
  // next state: swap first, then copy_start restarts, then the incoming word advances the counters
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    rect_idx_d    = rect_idx_q;
    front_sel_d   = front_sel_q;
    frame_ready_d = frame_ready_q;
    overrun_d     = overrun_q;
    if (state_q == DONE && swap) begin
      front_sel_d   = ~front_sel_q;
      frame_ready_d = 1'b0;
      state_d       = IDLE;
    end
    if (copy_start) begin
      state_d       = RECV;
      word_cnt_d    = '0;
      rect_idx_d    = '0;
      frame_ready_d = 1'b0;
    end
    rx        = copy_start || state_q == RECV;
    we        = rx && din_valid;
    wr_field  = copy_start ? 3'd0 : word_cnt_q;
    wr_idx    = copy_start ? '0 : rect_idx_q;
    wr_bank   = ~front_sel_d;
    last_word = wr_field == 3'(WORDS_PER_RECT-1);
    last_rect = wr_idx == IW'(RECT_COUNT-1);
    if (we) begin
      word_cnt_d = last_word ? 3'd0 : 3'(wr_field + 3'd1);
      if (last_word && !last_rect) rect_idx_d = IW'(wr_idx + 1'b1);
      if (last_word && last_rect) begin
        state_d       = DONE;
        frame_ready_d = 1'b1;
      end
    end
    if (din_valid && !rx) overrun_d = 1'b1;
  end
  // control state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      word_cnt_q    <= '0;
      rect_idx_q    <= '0;
      front_sel_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      rect_idx_q    <= rect_idx_d;
      front_sel_q   <= front_sel_d;
      frame_ready_q <= frame_ready_d;
      overrun_q     <= overrun_d;
    end
  end
  rect_bank #(.RECT_COUNT(RECT_COUNT), .IW(IW)) u_bank (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wr_bank  (wr_bank),
    .wr_idx   (wr_idx),
    .wr_field (wr_field),
    .wr_data  (din),
    .rd_bank  (front_sel_q),
    .rd_idx   (rd_idx),
    .rd_data  (rd_rect)
  );
  assign rd_flags    = rd_rect.flags;
  assign rd_x        = rd_rect.x;
  assign rd_y        = rd_rect.y;
  assign rd_w        = rd_rect.w;
  assign rd_h        = rd_rect.h;
  assign rd_color    = rd_rect.color;
  assign frame_ready = frame_ready_q;
  assign front_sel   = front_sel_q;
  assign overrun     = overrun_q;
  assign busy        = state_q == RECV;
endmodule

// File: tb/tb_rect_stream_receiver.sv
// tb_rect_stream_receiver: directed tests of stream assembly, bank swap and flag behaviour
module tb_rect_stream_receiver;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        copy_start = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        swap = 1'b0;
  logic [5:0]  rd_idx = '0;
  logic [15:0] rd_flags, rd_x, rd_y, rd_w, rd_h, rd_color;
  logic        frame_ready, front_sel, overrun, busy;
  int          n_cmp = 0;
  int          n_bad = 0;

  rect_stream_receiver dut (
    .clk(clk), .reset(reset), .copy_start(copy_start), .din(din), .din_valid(din_valid),
    .swap(swap), .rd_idx(rd_idx), .rd_flags(rd_flags), .rd_x(rd_x), .rd_y(rd_y), .rd_w(rd_w),
    .rd_h(rd_h), .rd_color(rd_color), .frame_ready(frame_ready), .front_sel(front_sel),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] fld(input int f);
    case (f)
      0: return rd_flags;
      1: return rd_x;
      2: return rd_y;
      3: return rd_w;
      4: return rd_h;
      default: return rd_color;
    endcase
  endfunction

  task automatic stream(input logic [15:0] base, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      din = 16'(base + i);
      din_valid = 1'b1;
      tick();
      if (gaps) begin
        din_valid = 1'b0;
        din = 16'hDEAD;
        tick();
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic start();
    copy_start = 1'b1;
    tick();
    copy_start = 1'b0;
  endtask

  task automatic do_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic rd(input int i);
    rd_idx = 6'(i);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({rd_flags, rd_x, rd_y, rd_w, rd_h, rd_color} !== 96'h0) begin
      n_bad++; $display("FAIL reset_rd got %h want 0", {rd_flags, rd_x, rd_y, rd_w, rd_h, rd_color});
    end
    n_cmp++;
    if ({frame_ready, front_sel, overrun, busy} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags got %b want 0000", {frame_ready, front_sel, overrun, busy});
    end
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({frame_ready, front_sel, overrun, busy} !== 4'b0000) begin
      n_bad++; $display("FAIL idle_flags got %b want 0000", {frame_ready, front_sel, overrun, busy});
    end
  endtask

  task automatic test_full_frame();
    start();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL full_busy got %b want 1", busy); end
    stream(16'h0000, 383, 0);
    n_cmp++;
    if (frame_ready !== 1'b0) begin n_bad++; $display("FAIL full_early_ready got %b want 0", frame_ready); end
    stream(16'h017F, 1, 0);
    n_cmp++;
    if ({frame_ready, busy} !== 2'b10) begin
      n_bad++; $display("FAIL full_ready got %b want 10", {frame_ready, busy});
    end
    do_swap();
    n_cmp++;
    if ({front_sel, frame_ready, busy} !== 3'b100) begin
      n_bad++; $display("FAIL full_swap got %b want 100", {front_sel, frame_ready, busy});
    end
    rd(2);
    for (int f = 0; f < 6; f++) begin
      n_cmp++;
      if (fld(f) !== 16'(12 + f)) begin
        n_bad++; $display("FAIL full_rec2_f%0d got %h want %h", f, fld(f), 16'(12 + f));
      end
    end
  endtask

  task automatic test_gapped();
    start();
    stream(16'h0000, 384, 1);
    n_cmp++;
    if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL gap_ready got %b want 1", frame_ready); end
    do_swap();
    n_cmp++;
    if (front_sel !== 1'b0) begin n_bad++; $display("FAIL gap_front got %b want 0", front_sel); end
    rd(63);
    for (int f = 0; f < 6; f++) begin
      n_cmp++;
      if (fld(f) !== 16'(16'h017A + f)) begin
        n_bad++; $display("FAIL gap_rec63_f%0d got %h want %h", f, fld(f), 16'(16'h017A + f));
      end
    end
    rd(0);
    n_cmp++;
    if ({rd_flags, rd_color} !== 32'h0000_0005) begin
      n_bad++; $display("FAIL gap_rec0 got %h want 00000005", {rd_flags, rd_color});
    end
  endtask

  task automatic test_mid_swap_and_restart();
    start();
    stream(16'hB000, 100, 0);
    do_swap();
    n_cmp++;
    if ({front_sel, frame_ready, busy} !== 3'b001) begin
      n_bad++; $display("FAIL mid_swap got %b want 001", {front_sel, frame_ready, busy});
    end
    rd(63);
    n_cmp++;
    if ({rd_flags, rd_color} !== 32'h017A_017F) begin
      n_bad++; $display("FAIL mid_front got %h want 017a017f", {rd_flags, rd_color});
    end
    stream(16'hB000 + 100, 100, 0);
    copy_start = 1'b1;
    din = 16'hA000;
    din_valid = 1'b1;
    tick();
    copy_start = 1'b0;
    stream(16'hA001, 383, 0);
    n_cmp++;
    if (frame_ready !== 1'b1) begin n_bad++; $display("FAIL restart_ready got %b want 1", frame_ready); end
    do_swap();
    rd(0);
    for (int f = 0; f < 6; f++) begin
      n_cmp++;
      if (fld(f) !== 16'(16'hA000 + f)) begin
        n_bad++; $display("FAIL restart_rec0_f%0d got %h want %h", f, fld(f), 16'(16'hA000 + f));
      end
    end
    rd(63);
    n_cmp++;
    if ({rd_flags, rd_color} !== 32'hA17A_A17F) begin
      n_bad++; $display("FAIL restart_rec63 got %h want a17aa17f", {rd_flags, rd_color});
    end
  endtask

  task automatic test_overrun_idle();
    n_cmp++;
    if ({overrun, busy, front_sel} !== 3'b001) begin
      n_bad++; $display("FAIL pre_overrun got %b want 001", {overrun, busy, front_sel});
    end
    stream(16'hFFFF, 3, 0);
    n_cmp++;
    if ({overrun, busy, frame_ready} !== 3'b100) begin
      n_bad++; $display("FAIL idle_overrun got %b want 100", {overrun, busy, frame_ready});
    end
    rd(0);
    n_cmp++;
    if ({rd_flags, rd_color} !== 32'hA000_A005) begin
      n_bad++; $display("FAIL idle_rec0 got %h want a000a005", {rd_flags, rd_color});
    end
  endtask

  task automatic test_done_swap_start();
    start();
    stream(16'hC000, 384, 0);
    n_cmp++;
    if ({frame_ready, front_sel} !== 2'b11) begin
      n_bad++; $display("FAIL done_state got %b want 11", {frame_ready, front_sel});
    end
    swap = 1'b1;
    copy_start = 1'b1;
    din = 16'h5000;
    din_valid = 1'b1;
    tick();
    swap = 1'b0;
    copy_start = 1'b0;
    din_valid = 1'b0;
    n_cmp++;
    if ({front_sel, busy, frame_ready} !== 3'b010) begin
      n_bad++; $display("FAIL done_swapstart got %b want 010", {front_sel, busy, frame_ready});
    end
    rd(0);
    for (int f = 0; f < 6; f++) begin
      n_cmp++;
      if (fld(f) !== 16'(16'hC000 + f)) begin
        n_bad++; $display("FAIL done_rec0_f%0d got %h want %h", f, fld(f), 16'(16'hC000 + f));
      end
    end
    stream(16'h5001, 383, 0);
    do_swap();
    n_cmp++;
    if (front_sel !== 1'b1) begin n_bad++; $display("FAIL second_front got %b want 1", front_sel); end
    rd(0);
    n_cmp++;
    if ({rd_flags, rd_x, rd_color} !== 48'h5000_5001_5005) begin
      n_bad++; $display("FAIL second_rec0 got %h want 500050015005", {rd_flags, rd_x, rd_color});
    end
    rd(63);
    n_cmp++;
    if ({rd_flags, rd_color} !== 32'h517A_517F) begin
      n_bad++; $display("FAIL second_rec63 got %h want 517a517f", {rd_flags, rd_color});
    end
  endtask

  task automatic test_reset_mid_stream();
    start();
    stream(16'h7000, 10, 0);
    reset = 1'b0;
    #2;
    n_cmp++;
    if ({busy, front_sel, overrun, frame_ready} !== 4'b0000) begin
      n_bad++; $display("FAIL async_reset got %b want 0000", {busy, front_sel, overrun, frame_ready});
    end
    n_cmp++;
    if ({rd_flags, rd_color} !== 32'h0) begin
      n_bad++; $display("FAIL async_reset_rd got %h want 0", {rd_flags, rd_color});
    end
    tick();
    reset = 1'b1;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL post_reset_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gapped();
    test_mid_swap_and_restart();
    test_overrun_idle();
    test_done_swap_start();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
